serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract engine that time-shares one 1-bit full-adder cell across a WIDTH-bit operation, one bit per clock, LSB first.
- Sits between a requesting controller (start/done handshake) and the single full-adder datapath.
- Holds the operand shift registers, carry flop, bit counter and result register.
- Trades latency for area against a ripple adder.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  single system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse or level; sampled only in IDLE.
- sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high from the cycle after accepted start through the final bit cycle.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; held stable from done until the next accepted start.
- cout  output  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; shift registers, carry flop and counter cleared. Release is synchronous to clk.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1, load a_sr=a and b_sr=(sub ? ~b : b).
  - Set carry=sub and cnt=0, then go to RUN.
  - start=0 stays in IDLE.
- RUN, each cycle:
  - The full-adder cell computes s and c from a_sr[0], b_sr[0] and carry.
  - sum_sr shifts right with s entering at bit WIDTH-1.
  - a_sr and b_sr shift right by 1.
  - carry<=c; cnt<=cnt+1.
  - When cnt==WIDTH-1: capture the carry-in of that bit (c_msb_in) and go to DONE.
- DONE (one cycle):
  - sum<=sum_sr, cout<=final carry, ovf<=c_msb_in^final carry.
  - done=1 for exactly this cycle, then return to IDLE.
- Latency: start accepted at edge 0; done high during cycle WIDTH+1 after acceptance; busy high for exactly WIDTH cycles.
- start while in RUN or DONE is ignored and not queued. The requester must re-assert start in IDLE.
- Back-to-back: start held high is re-accepted the first IDLE cycle after DONE, giving a WIDTH+2-cycle throughput.
- Changes to a, b or sub after acceptance have no effect on the running operation.
- Reset mid-operation: aborts immediately, no done pulse, outputs return to reset values.
- sum, cout and ovf update only in DONE; between operations they hold their last result.
- cnt width is clog2(WIDTH)+1; wrap is not reachable.

Decomposition:
- Shared package holds the FSM state enum (IDLE/RUN/DONE, 2-bit encoding) and the OP_ADD/OP_SUB constants for sub.
- One sub-module, fa_cell: purely combinational 1-bit full adder (inputs x, y, cin; outputs s, co).
  - s = x^y^cin
  - co = majority(x, y, cin)
- The controller instantiates exactly one fa_cell.

Test Plan:
- WIDTH=8, add 0x35+0x4A -> done at cycle 9, sum=0x7F, cout=0, ovf=0; busy high for exactly 8 cycles.
- Add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0.
- Add 0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
- Sub 0x10-0x20 -> sum=0xF0, cout=0, ovf=0.
- Sub 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
- start pulsed again at cycle 3 of a run with different operands -> ignored; first result unchanged, single done pulse.
- rst_n low at cycle 4 of a run -> busy, done, sum, cout and ovf all 0 immediately, FSM in IDLE. A new start after release yields the correct result.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial add/subtract engine: FSM states and op encoding.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/done request bus between a requesting controller and the serial adder.
interface serial_add_if #(parameter int WIDTH = 8);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, sub, a, b, input busy, done, sum, cout, ovf);
  modport slave  (input start, sub, a, b, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational 1-bit full adder; the only arithmetic in the engine.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ cin;
  assign co = (x & y) | (x & cin) | (y & cin);
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell, LSB first, one bit per clock.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  serial_add_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             busy_q, done_q, cout_q, ovf_q;
  logic [WIDTH-1:0] sum_q;
  logic             s, c;

  fa_cell u_fa (.x(a_sr[0]), .y(b_sr[0]), .cin(carry), .s(s), .co(c));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          // Subtract as A + ~B + 1: the +1 rides in on the initial carry.
          a_sr   <= bus.a;
          b_sr   <= (bus.sub == OP_SUB) ? ~bus.b : bus.b;
          carry  <= bus.sub;
          cnt    <= '0;
          busy_q <= 1'b1;
          state  <= RUN;
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {s, sum_sr[WIDTH-1:1]};
          carry  <= c;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            // Result registers load on the MSB edge so they are valid while done is high;
            // carry here is the carry into the MSB.
            busy_q <= 1'b0;
            done_q <= 1'b1;
            sum_q  <= {s, sum_sr[WIDTH-1:1]};
            cout_q <= c;
            ovf_q  <= carry ^ c;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized and directed bench for serial_add_ctrl against an arithmetic reference model.
module tb_serial_add_ctrl;
  import serial_add_ctrl_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_add_if #(.WIDTH(W)) bus ();
  serial_add_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  int         done_cyc, busy_cnt, done_cnt;
  logic [W-1:0] sum_d, sum_end;
  logic       cout_d, ovf_d;

  // Reference: plain integer arithmetic on the operand values.
  task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [W-1:0] es, output logic ec, output logic eo);
    int ua, ub, sa, sb, r;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 2**(W-1)) ? ua - 2**W : ua;
    sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
    if (s) begin
      es = W'(ua - ub);
      ec = (ua >= ub);
      r  = sa - sb;
    end else begin
      es = W'(ua + ub);
      ec = (ua + ub >= 2**W);
      r  = sa + sb;
    end
    eo = (r > 2**(W-1) - 1) || (r < -(2**(W-1)));
  endtask

  // Drive one request and observe W+5 cycles after acceptance (bounded).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input bit repulse);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sub = s; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    done_cyc = 0; busy_cnt = 0; done_cnt = 0;
    for (int n = 1; n <= W + 5; n++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = n; sum_d = bus.sum; cout_d = bus.cout; ovf_d = bus.ovf;
        end
      end
      if (n == 2) begin bus.a = ~a; bus.b = a; bus.sub = ~s; end
      if (repulse && n == 3) bus.start = 1'b1;
      if (n == 4) bus.start = 1'b0;
      if (n < W + 5) begin @(posedge clk); #1; end
    end
    sum_end = bus.sum;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.sub = OP_ADD; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] va [5] = '{8'h35, 8'hFF, 8'h7F, 8'h10, 8'h80};
    logic [W-1:0] vb [5] = '{8'h4A, 8'h01, 8'h01, 8'h20, 8'h01};
    logic         vs [5] = '{OP_ADD, OP_ADD, OP_ADD, OP_SUB, OP_SUB};
    logic [W-1:0] es; logic ec, eo;
    for (int i = 0; i < 5; i++) begin
      ref_op(va[i], vb[i], vs[i], es, ec, eo);
      do_op(va[i], vb[i], vs[i], 1'b0);
      checks++;
      if (sum_d !== es || cout_d !== ec || ovf_d !== eo) begin
        failures++;
        $display("FAIL directed_%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 i, sum_d, cout_d, ovf_d, es, ec, eo);
      end
      checks++;
      if (done_cyc !== W + 1 || busy_cnt !== W || done_cnt !== 1) begin
        failures++;
        $display("FAIL timing_%0d got done_cyc=%0d busy_cycles=%0d done_pulses=%0d want %0d %0d 1",
                 i, done_cyc, busy_cnt, done_cnt, W + 1, W);
      end
      checks++;
      if (sum_end !== es) begin
        failures++;
        $display("FAIL hold_%0d got sum=%h want %h", i, sum_end, es);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] es; logic ec, eo;
    ref_op(8'h5C, 8'h27, OP_ADD, es, ec, eo);
    do_op(8'h5C, 8'h27, OP_ADD, 1'b1);
    checks++;
    if (sum_d !== es || cout_d !== ec || ovf_d !== eo || done_cnt !== 1 || done_cyc !== W + 1) begin
      failures++;
      $display("FAIL ignore_start got sum=%h cout=%b ovf=%b pulses=%0d cyc=%0d want sum=%h cout=%b ovf=%b 1 %0d",
               sum_d, cout_d, ovf_d, done_cnt, done_cyc, es, ec, eo, W + 1);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] es; logic ec, eo;
    int seen_done;
    @(negedge clk);
    bus.a = 8'h12; bus.b = 8'h34; bus.sub = OP_ADD; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== '0 || dut.state !== IDLE) begin
      failures++;
      $display("FAIL reset_mid got busy=%b done=%b sum=%h cout=%b ovf=%b state=%0d want all 0, IDLE",
               bus.busy, bus.done, bus.sum, bus.cout, bus.ovf, dut.state);
    end
    seen_done = 0;
    for (int n = 0; n < W + 2; n++) begin
      @(posedge clk); #1;
      if (bus.done) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      failures++;
      $display("FAIL reset_no_done got pulses=%0d want 0", seen_done);
    end
    @(negedge clk); rst_n = 1'b1;
    ref_op(8'hC3, 8'h5A, OP_SUB, es, ec, eo);
    do_op(8'hC3, 8'h5A, OP_SUB, 1'b0);
    checks++;
    if (sum_d !== es || cout_d !== ec || ovf_d !== eo || done_cyc !== W + 1) begin
      failures++;
      $display("FAIL after_reset got sum=%h cout=%b ovf=%b cyc=%0d want sum=%h cout=%b ovf=%b cyc=%0d",
               sum_d, cout_d, ovf_d, done_cyc, es, ec, eo, W + 1);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, es; logic s, ec, eo;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom); b = W'($urandom); s = 1'($urandom);
      ref_op(a, b, s, es, ec, eo);
      do_op(a, b, s, 1'($urandom));
      checks++;
      if (sum_d !== es || cout_d !== ec || ovf_d !== eo || done_cnt !== 1) begin
        failures++;
        $display("FAIL random_%0d a=%h b=%h sub=%b got sum=%h cout=%b ovf=%b pulses=%0d want sum=%h cout=%b ovf=%b",
                 i, a, b, s, sum_d, cout_d, ovf_d, done_cnt, es, ec, eo);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] es1, es2; logic ec1, eo1, ec2, eo2;
    int d1, d2;
    logic [W-1:0] s1, s2;
    ref_op(8'hA5, 8'h3C, OP_ADD, es1, ec1, eo1);
    ref_op(8'h11, 8'h99, OP_SUB, es2, ec2, eo2);
    @(negedge clk);
    bus.a = 8'hA5; bus.b = 8'h3C; bus.sub = OP_ADD; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.a = 8'h11; bus.b = 8'h99; bus.sub = OP_SUB;
    d1 = 0; d2 = 0; s1 = '0; s2 = '0;
    for (int n = 1; n <= 2 * W + 8; n++) begin
      if (bus.done) begin
        if (d1 == 0) begin d1 = n; s1 = bus.sum; end
        else if (d2 == 0) begin d2 = n; s2 = bus.sum; bus.start = 1'b0; end
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    checks++;
    if (d1 !== W + 1 || d2 !== 2 * W + 3) begin
      failures++;
      $display("FAIL b2b_timing got done at %0d and %0d want %0d and %0d", d1, d2, W + 1, 2 * W + 3);
    end
    checks++;
    if (s1 !== es1 || s2 !== es2) begin
      failures++;
      $display("FAIL b2b_results got %h,%h want %h,%h", s1, s2, es1, es2);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
